// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, LSB first,
// one full-subtractor cell with a registered borrow, start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] work;
  logic             borrow;
  logic             a_msb;
  logic             b_msb;

  logic             a_i;
  logic             b_i;
  logic             d;
  logic             borrow_next;
  logic [WIDTH-1:0] work_next;
  logic             last;
  logic             accept;

  always_comb begin
    a_i         = a_sh[0];
    b_i         = b_sh[0];
    d           = a_i ^ b_i ^ borrow;
    borrow_next = (~a_i & b_i) | (~(a_i ^ b_i) & borrow);
    work_next   = {d, work[WIDTH-1:1]};
    last        = (cnt == CW'(WIDTH - 1));
    accept      = start && ((state == IDLE) || (state == DONE));

    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Results are captured from the post-shift values so the final bit and
  // final borrow land in the same edge that enters DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      work   <= '0;
      borrow <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);

      if (accept) begin
        a_sh   <= a;
        b_sh   <= b;
        a_msb  <= a[WIDTH-1];
        b_msb  <= b[WIDTH-1];
        borrow <= bin;
        cnt    <= '0;
      end else if (state == RUN) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        work   <= work_next;
        borrow <= borrow_next;
        cnt    <= cnt + CW'(1);
        if (last) begin
          diff <= work_next;
          bout <= borrow_next;
          zero <= (work_next == '0);
          ovf  <= (a_msb != b_msb) && (d != a_msb);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4): stimulus pushes expected
// results, a negedge monitor pops and compares on every done pulse.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         zero;
  logic         ovf;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
    logic         ovf;
  } res_t;

  res_t exp_q[$];
  int   vectors;
  int   checks;
  int   miscompares;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .zero  (zero),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: any done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk("diff", int'(diff), int'(e.diff));
        chk("bout", int'(bout), int'(e.bout));
        chk("zero", int'(zero), int'(e.zero));
        chk("ovf",  int'(ovf),  int'(e.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic bi);
    start = s;
    a     = av;
    b     = bv;
    bin   = bi;
  endtask

  // Issue one operation, then check busy/done timing edge by edge.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                        input logic [W-1:0] ed, input logic eb, input logic ez,
                        input logic eo);
    @(negedge clk);
    drive(1'b1, av, bv, bi);
    exp_q.push_back('{diff: ed, bout: eb, zero: ez, ovf: eo});
    vectors++;
    @(posedge clk); #1;
    drive(1'b0, '0, '0, 1'b0);
    chk("busy_after_accept", int'(busy), 1);
    for (int k = 1; k <= W; k++) begin
      @(posedge clk); #1;
      chk("busy_timing", int'(busy), (k < W) ? 1 : 0);
      chk("done_timing", int'(done), (k == W) ? 1 : 0);
    end
    @(posedge clk); #1;
    chk("done_one_cycle", int'(done), 0);
  endtask

  initial begin
    vectors     = 0;
    checks      = 0;
    miscompares = 0;
    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_diff", int'(diff), 0);
    chk("rst_bout", int'(bout), 0);
    chk("rst_zero", int'(zero), 0);
    chk("rst_ovf",  int'(ovf),  0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle_busy", int'(busy), 0);
      chk("idle_done", int'(done), 0);
    end

    run_op(4'd7, 4'd3, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0);
    run_op(4'd3, 4'd9, 1'b0, 4'hA, 1'b1, 1'b0, 1'b1);
    run_op(4'd5, 4'd5, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    run_op(4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0);
    run_op(4'd8, 4'd1, 1'b0, 4'h7, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("hold_diff", int'(diff), 7);
      chk("hold_bout", int'(bout), 0);
      chk("hold_zero", int'(zero), 0);
      chk("hold_ovf",  int'(ovf),  1);
      chk("hold_done", int'(done), 0);
    end

    // Back-to-back: start pulsed mid-RUN (ignored), then held across DONE.
    @(negedge clk);
    drive(1'b1, 4'd6, 4'd2, 1'b0);
    exp_q.push_back('{diff: 4'h4, bout: 1'b0, zero: 1'b0, ovf: 1'b0});
    vectors++;
    @(posedge clk); #1;                 // E0
    drive(1'b0, '0, '0, 1'b0);
    @(posedge clk); #1;                 // E0+1
    drive(1'b1, 4'd15, 4'd15, 1'b1);
    @(posedge clk); #1;                 // E0+2
    drive(1'b0, 4'd15, 4'd15, 1'b1);
    @(posedge clk); #1;                 // E0+3
    drive(1'b1, 4'd2, 4'd1, 1'b0);
    exp_q.push_back('{diff: 4'h1, bout: 1'b0, zero: 1'b0, ovf: 1'b0});
    vectors++;
    @(posedge clk); #1;                 // E0+4: DONE
    chk("b2b_done1", int'(done), 1);
    chk("b2b_busy_in_done", int'(busy), 0);
    @(posedge clk); #1;                 // E0+5: re-accepted
    drive(1'b0, '0, '0, 1'b0);
    chk("b2b_busy_reassert", int'(busy), 1);
    chk("b2b_done_low", int'(done), 0);
    for (int k = 1; k <= W; k++) begin
      @(posedge clk); #1;
      chk("b2b_done2_timing", int'(done), (k == W) ? 1 : 0);
    end
    @(posedge clk); #1;

    // Reset asserted for the edge that would end RUN cycle 2.
    @(negedge clk);
    drive(1'b1, 4'd9, 4'd4, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, '0, '0, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_diff", int'(diff), 0);
    chk("midrst_bout", int'(bout), 0);
    chk("midrst_zero", int'(zero), 0);
    chk("midrst_ovf",  int'(ovf),  0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_done", int'(done), 0);
      chk("midrst_diff_hold", int'(diff), 0);
    end

    run_op(4'd9, 4'd4, 1'b0, 4'h5, 1'b0, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
